// File: rtl/miim_pkg.sv
// Shared definitions for the MIIM management-port arbiter: bus widths,
// default timeout budgets, FSM state encoding and requester identifiers.
package miim_pkg;

  localparam int MIIM_ADDR_W       = 5;
  localparam int MIIM_DATA_W       = 16;
  localparam int MIIM_START_TO_DEF = 64;
  localparam int MIIM_DONE_TO_DEF  = 4096;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_FINISH     = 3'd4
  } miim_state_e;

  // Requester identity; also the encoding of the round-robin pointer.
  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } miim_owner_e;

  // One management command as presented by a requester.
  typedef struct packed {
    logic                   wr;
    logic [MIIM_ADDR_W-1:0] phyad;
    logic [MIIM_ADDR_W-1:0] regad;
    logic [MIIM_DATA_W-1:0] wrdata;
  } miim_cmd_t;

endpackage

// File: rtl/miim_arbiter_if.sv
// Bundle of the two requester ports and the MAC-side MIIM port.
// The arbiter connects through the slave modport; the environment that
// plays requesters and MAC uses the master modport.
interface miim_arbiter_if;
  import miim_pkg::*;

  // Requester A (power-up configurator)
  logic                   a_req;
  logic                   a_wr;
  logic [MIIM_ADDR_W-1:0] a_phyad;
  logic [MIIM_ADDR_W-1:0] a_regad;
  logic [MIIM_DATA_W-1:0] a_wrdata;
  logic                   a_gnt;
  logic                   a_done;
  logic                   a_err;
  logic [MIIM_DATA_W-1:0] a_rddata;

  // Requester B (run-time status poller)
  logic                   b_req;
  logic                   b_wr;
  logic [MIIM_ADDR_W-1:0] b_phyad;
  logic [MIIM_ADDR_W-1:0] b_regad;
  logic [MIIM_DATA_W-1:0] b_wrdata;
  logic                   b_gnt;
  logic                   b_done;
  logic                   b_err;
  logic [MIIM_DATA_W-1:0] b_rddata;

  // MAC controller MIIM port
  logic [MIIM_ADDR_W-1:0] miim_phyad;
  logic [MIIM_ADDR_W-1:0] miim_regad;
  logic [MIIM_DATA_W-1:0] miim_wrdata;
  logic                   miim_wren;
  logic                   miim_rden;
  logic                   miim_busy;
  logic [MIIM_DATA_W-1:0] miim_rddata;
  logic                   miim_rddata_valid;

  modport slave (
    input  a_req, a_wr, a_phyad, a_regad, a_wrdata,
    input  b_req, b_wr, b_phyad, b_regad, b_wrdata,
    input  miim_busy, miim_rddata, miim_rddata_valid,
    output a_gnt, a_done, a_err, a_rddata,
    output b_gnt, b_done, b_err, b_rddata,
    output miim_phyad, miim_regad, miim_wrdata, miim_wren, miim_rden
  );

  modport master (
    output a_req, a_wr, a_phyad, a_regad, a_wrdata,
    output b_req, b_wr, b_phyad, b_regad, b_wrdata,
    output miim_busy, miim_rddata, miim_rddata_valid,
    input  a_gnt, a_done, a_err, a_rddata,
    input  b_gnt, b_done, b_err, b_rddata,
    input  miim_phyad, miim_regad, miim_wrdata, miim_wren, miim_rden
  );

endinterface

// File: rtl/miim_arbiter.sv
// Two-requester arbiter for the MAC's single MIIM management port.
// One transaction in flight at a time: grant, strobe, wait for the MAC's
// busy to rise and fall (each bounded by a timeout), then report done,
// error and read data to the owning requester. Round-robin on contention.
module miim_arbiter
  import miim_pkg::*;
#(
  parameter int START_TO = MIIM_START_TO_DEF,
  parameter int DONE_TO  = MIIM_DONE_TO_DEF
) (
  input  logic          clk,
  input  logic          rst,
  miim_arbiter_if.slave bus
);

  // Counter is sized for the longer (done) budget and saturates, so a
  // stalled MAC can never wrap it back below a limit.
  localparam int               CNT_W     = $clog2(DONE_TO + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO);
  localparam logic [CNT_W-1:0] DONE_LIM  = CNT_W'(DONE_TO);

  // Control state
  miim_state_e            state_q, state_d;
  miim_owner_e            owner_q, owner_d;
  miim_owner_e            rr_q, rr_d;
  logic                   wr_q, wr_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Read data captured from the MAC during the current transaction
  logic [MIIM_DATA_W-1:0] cap_q, cap_d;

  // Registered outputs
  logic                   a_gnt_q, a_gnt_d;
  logic                   b_gnt_q, b_gnt_d;
  logic                   a_done_q, a_done_d;
  logic                   b_done_q, b_done_d;
  logic                   a_err_q, a_err_d;
  logic                   b_err_q, b_err_d;
  logic [MIIM_DATA_W-1:0] a_rddata_q, a_rddata_d;
  logic [MIIM_DATA_W-1:0] b_rddata_q, b_rddata_d;
  logic [MIIM_ADDR_W-1:0] phyad_q, phyad_d;
  logic [MIIM_ADDR_W-1:0] regad_q, regad_d;
  logic [MIIM_DATA_W-1:0] wrdata_q, wrdata_d;
  logic                   wren_q, wren_d;
  logic                   rden_q, rden_d;

  // Arbitration helpers
  miim_cmd_t              cmd_a, cmd_b, cmd_sel;
  logic                   pick_b;

  // Next-state and next-output logic for the transaction FSM
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    wr_d       = wr_q;
    err_d      = err_q;
    cap_d      = cap_q;
    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    phyad_d    = phyad_q;
    regad_d    = regad_q;
    wrdata_d   = wrdata_q;
    a_rddata_d = a_rddata_q;
    b_rddata_d = b_rddata_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_done_d   = 1'b0;
    b_done_d   = 1'b0;
    a_err_d    = 1'b0;
    b_err_d    = 1'b0;
    wren_d     = 1'b0;
    rden_d     = 1'b0;

    cmd_a.wr     = bus.a_wr;
    cmd_a.phyad  = bus.a_phyad;
    cmd_a.regad  = bus.a_regad;
    cmd_a.wrdata = bus.a_wrdata;
    cmd_b.wr     = bus.b_wr;
    cmd_b.phyad  = bus.b_phyad;
    cmd_b.regad  = bus.b_regad;
    cmd_b.wrdata = bus.b_wrdata;

    // B wins when it is alone, or when both ask and the pointer favours B.
    pick_b  = bus.b_req && (!bus.a_req || (rr_q == OWN_B));
    cmd_sel = pick_b ? cmd_b : cmd_a;

    case (state_q)
      ST_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          owner_d  = pick_b ? OWN_B : OWN_A;
          wr_d     = cmd_sel.wr;
          phyad_d  = cmd_sel.phyad;
          regad_d  = cmd_sel.regad;
          wrdata_d = cmd_sel.wrdata;
          err_d    = 1'b0;
          cap_d    = '0;
          a_gnt_d  = !pick_b;
          b_gnt_d  = pick_b;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        wren_d  = wr_q;
        rden_d  = !wr_q;
        cnt_d   = '0;
        state_d = ST_WAIT_START;
      end

      ST_WAIT_START: begin
        // Busy seen takes priority over an expiring budget in the same cycle.
        if (bus.miim_busy) begin
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end else if (cnt_q >= START_LIM) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end

      ST_WAIT_DONE: begin
        if (!wr_q && bus.miim_rddata_valid) begin
          cap_d = bus.miim_rddata;
        end
        if (!bus.miim_busy) begin
          state_d = ST_FINISH;
        end else if (cnt_q >= DONE_LIM) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        if (owner_q == OWN_A) begin
          a_done_d = 1'b1;
          a_err_d  = err_q;
          if (!wr_q) begin
            a_rddata_d = cap_q;
          end
        end else begin
          b_done_d = 1'b1;
          b_err_d  = err_q;
          if (!wr_q) begin
            b_rddata_d = cap_q;
          end
        end
        // Next contention goes to whoever did not just finish.
        rr_d    = (owner_q == OWN_A) ? OWN_B : OWN_A;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers; reset abandons any transaction silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_A;
      rr_q       <= OWN_A;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rddata_q <= '0;
      b_rddata_q <= '0;
      phyad_q    <= '0;
      regad_q    <= '0;
      wrdata_q   <= '0;
      wren_q     <= 1'b0;
      rden_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_done_q   <= a_done_d;
      b_done_q   <= b_done_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      a_rddata_q <= a_rddata_d;
      b_rddata_q <= b_rddata_d;
      phyad_q    <= phyad_d;
      regad_q    <= regad_d;
      wrdata_q   <= wrdata_d;
      wren_q     <= wren_d;
      rden_q     <= rden_d;
    end
  end

  // Capture buffer is pure data; it is cleared at every grant instead
  always_ff @(posedge clk) begin
    cap_q <= cap_d;
  end

  assign bus.a_gnt       = a_gnt_q;
  assign bus.b_gnt       = b_gnt_q;
  assign bus.a_done      = a_done_q;
  assign bus.b_done      = b_done_q;
  assign bus.a_err       = a_err_q;
  assign bus.b_err       = b_err_q;
  assign bus.a_rddata    = a_rddata_q;
  assign bus.b_rddata    = b_rddata_q;
  assign bus.miim_phyad  = phyad_q;
  assign bus.miim_regad  = regad_q;
  assign bus.miim_wrdata = wrdata_q;
  assign bus.miim_wren   = wren_q;
  assign bus.miim_rden   = rden_q;

endmodule
